// File: rtl/regfile32x64.sv
// ---------------------------------------------------------------------------
// regfile32x64
//
// Purpose:
//   A file of 32 registers, 64 bits each. Registers 0-30 are writable.
//   Register 31 always reads zero. A sequential clear controller zeroes
//   registers 0..30, one per cycle, after a single-cycle clr_req.
//   Writes that arrive while the clear runs are discarded and flagged.
//
// Ports:
//   clk      in   1      single clock, rising edge
//   reset    in   1      synchronous, active-high
//   wr_en    in   1      write request for the current cycle
//   wr_addr  in   5      destination register index (31 = sink, ignored)
//   wr_data  in   64     write value
//   clr_req  in   1      start a sequential clear (ignored while clearing)
//   busy     out  1      registered, high while the clear sequence runs
//   wr_drop  out  1      one-cycle flag: a write was discarded during clear
//   q        out  32x64  all register contents, q[i] is register i
//
// Configuration:
//   REGFILE_BYPASS_EN - when defined, an accepted IDLE write is visible on
//                       q[wr_addr] in the same cycle (write-through).
//                       When undefined, q shows registered state only.
// ---------------------------------------------------------------------------
module regfile32x64 (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [63:0]           wr_data,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  wr_drop,
    output logic [31:0][63:0]     q
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         ptr_q, ptr_d;
    logic [30:0][63:0]  regs_q, regs_d;
    logic               busy_q, busy_d;
    logic               drop_q, drop_d;
    logic               wr_ok;

    // Index 31 is the zero register, so writes to it never count as real
    // writes: they neither update anything nor raise wr_drop.
    assign wr_ok = wr_en && (wr_addr != 5'd31);

    // Next-state logic for the controller and the register array.
    // In IDLE a write lands first; a simultaneous clr_req still starts the
    // clear, so the freshly written register gets wiped later on.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        regs_d  = regs_q;
        drop_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    for (int i = 0; i < 31; i++) begin
                        if (wr_addr == 5'(i)) begin
                            regs_d[i] = wr_data;
                        end
                    end
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = 5'd0;
                end
            end

            CLEAR: begin
                for (int i = 0; i < 31; i++) begin
                    if (ptr_q == 5'(i)) begin
                        regs_d[i] = '0;
                    end
                end
                drop_d = wr_ok;
                // Register 30 is the last one; 31 cycles in total.
                if (ptr_q == 5'd30) begin
                    state_d = IDLE;
                    ptr_d   = 5'd0;
                end else begin
                    ptr_d   = ptr_q + 5'd1;
                end
            end

            default: begin
                state_d = IDLE;
                ptr_d   = 5'd0;
            end
        endcase

        busy_d = (state_d == CLEAR);
    end

    // State register. Reset wins over everything, including a clear in
    // progress and a write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 5'd0;
            regs_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign busy    = busy_q;
    assign wr_drop = drop_q;

    // Read bus. q[31] is hard-wired to zero.
    always_comb begin
        q = '0;
        for (int i = 0; i < 31; i++) begin
            q[i] = regs_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        // Write-through only for writes that will actually be accepted.
        if (!reset && (state_q == IDLE) && wr_ok) begin
            for (int i = 0; i < 31; i++) begin
                if (wr_addr == 5'(i)) begin
                    q[i] = wr_data;
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_regfile32x64.sv
// ---------------------------------------------------------------------------
// tb_regfile32x64
//
// Purpose:
//   Self-checking bench for regfile32x64. It runs directed scenarios and
//   then a random phase. A reference model of the register file tracks the
//   expected contents, busy and wr_drop, and every output is compared to it
//   with immediate assertions.
//
// Ports: none (top-level bench).
// Configuration: honours REGFILE_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_regfile32x64;

    logic              clk;
    logic              reset;
    logic              wrEn;
    logic [4:0]        wrAddr;
    logic [63:0]       wrData;
    logic              clrReq;
    logic              busy;
    logic              wrDrop;
    logic [31:0][63:0] q;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    // Reference model: plain array of register values plus a clear cursor.
    logic [63:0] mReg [0:30];
    bit          mClearing;
    int          mNext;
    bit          mDrop;

    regfile32x64 dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wrEn),
        .wr_addr (wrAddr),
        .wr_data (wrData),
        .clr_req (clrReq),
        .busy    (busy),
        .wr_drop (wrDrop),
        .q       (q)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the input set for the coming cycle.
    task automatic setIn(input bit r, input bit we, input logic [4:0] a,
                         input logic [63:0] d, input bit c);
        reset  = r;
        wrEn   = we;
        wrAddr = a;
        wrData = d;
        clrReq = c;
    endtask

    // Advance one clock edge and update the model from the inputs that the
    // edge sampled.
    task automatic applyStimulus();
        bit validWr;
        @(posedge clk);
        validWr = wrEn && (wrAddr != 5'd31);
        if (reset) begin
            for (int i = 0; i < 31; i++) mReg[i] = '0;
            mClearing = 1'b0;
            mNext     = 0;
            mDrop     = 1'b0;
        end else if (mClearing) begin
            mDrop        = validWr;
            mReg[mNext]  = '0;
            mNext        = mNext + 1;
            if (mNext == 31) begin
                mClearing = 1'b0;
                mNext     = 0;
            end
        end else begin
            mDrop = 1'b0;
            if (validWr) mReg[wrAddr] = wrData;
            if (clrReq) begin
                mClearing = 1'b1;
                mNext     = 0;
            end
        end
        #1;
    endtask

    // Compare busy, wr_drop and the full q bus against the model.
    task automatic checkOutput(input string tag);
        logic [31:0][63:0] expQ;
        int idx;
        #2;
        expQ = '0;
        for (int i = 0; i < 31; i++) expQ[i] = mReg[i];
`ifdef REGFILE_BYPASS_EN
        if (!reset && !mClearing && wrEn && (wrAddr != 5'd31))
            expQ[wrAddr] = wrData;
`endif
        checkCount++;
        assert (busy === mClearing) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s busy observed %b expected %b", tag, busy, mClearing);
        end
        checkCount++;
        assert (wrDrop === mDrop) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s wr_drop observed %b expected %b", tag, wrDrop, mDrop);
        end
        checkCount++;
        assert (q === expQ) passCount++;
        else begin
            failCount++;
            idx = 0;
            for (int k = 31; k >= 0; k--) if (q[k] !== expQ[k]) idx = k;
            $error("[TB] FAIL %s q[%0d] observed %h expected %h", tag, idx, q[idx], expQ[idx]);
        end
    endtask

    // Plain value comparison for scenario-level counts.
    task automatic checkValue(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        int busyCnt;
        int dropCnt;
        bit r, we, c;

        for (int i = 0; i < 31; i++) mReg[i] = '0;
        mClearing = 1'b0;
        mNext     = 0;
        mDrop     = 1'b0;

        // Reset, with a write in the same cycle that must be lost.
        setIn(1, 1, 5'd3, 64'hAAAA_BBBB_CCCC_DDDD, 0);
        #1;
        applyStimulus();
        applyStimulus();
        setIn(0, 0, 0, 0, 0);
        checkOutput("reset");

        // Single write to register 5.
        setIn(0, 1, 5'd5, 64'hDEAD_BEEF_0000_0005, 0);
        checkOutput("wr5_same");
        applyStimulus();
        setIn(0, 0, 0, 0, 0);
        checkOutput("wr5_next");

        // Write to the zero register.
        setIn(0, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        checkOutput("wr31_same");
        applyStimulus();
        setIn(0, 0, 0, 0, 0);
        checkOutput("wr31_next");

        // Random writes in IDLE.
        for (int n = 0; n < 20; n++) begin
            setIn(0, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 0);
            checkOutput("rand_idle");
            applyStimulus();
        end

        // Fill 0-30 with i+1, then clear. A write is attempted at clear
        // cycle 3, a redundant clr_req at cycle 8 and a write to 31 at 12.
        for (int i = 0; i < 31; i++) begin
            setIn(0, 1, 5'(i), 64'(i + 1), 0);
            checkOutput("fill");
            applyStimulus();
        end
        setIn(0, 0, 0, 0, 1);
        checkOutput("clr_pulse");
        applyStimulus();
        busyCnt = 0;
        dropCnt = 0;
        for (int n = 1; n <= 34; n++) begin
            setIn(0, 0, 0, 0, 0);
            if (n == 3)  setIn(0, 1, 5'd30, 64'h1234, 0);
            if (n == 8)  setIn(0, 0, 0, 0, 1);
            if (n == 12) setIn(0, 1, 5'd31, 64'h55, 0);
            checkOutput("clear_seq");
            if (busy === 1'b1) busyCnt++;
            if (wrDrop === 1'b1) dropCnt++;
            applyStimulus();
        end
        checkValue("busy_cycles", busyCnt, 31);
        checkValue("drop_pulses", dropCnt, 1);

        // Reset in the middle of a clear.
        for (int i = 0; i < 31; i++) begin
            setIn(0, 1, 5'(i), 64'h100 + 64'(i), 0);
            applyStimulus();
        end
        setIn(0, 0, 0, 0, 1);
        applyStimulus();
        for (int n = 1; n < 10; n++) begin
            setIn(0, 0, 0, 0, 0);
            checkOutput("pre_abort");
            applyStimulus();
        end
        setIn(1, 0, 0, 0, 0);
        applyStimulus();
        setIn(0, 0, 0, 0, 0);
        checkOutput("abort");
        setIn(0, 1, 5'd2, 64'h0ABC_0002, 0);
        applyStimulus();
        setIn(0, 0, 0, 0, 0);
        checkOutput("post_abort_wr2");

        // Write and clr_req in the same IDLE cycle.
        setIn(0, 1, 5'd0, 64'h7, 1);
        checkOutput("wrclr_same");
        applyStimulus();
        setIn(0, 0, 0, 0, 0);
        checkOutput("wrclr_q0_7");
        checkValue("wrclr_q0_val", int'(q[0]), 7);
        applyStimulus();
        checkOutput("wrclr_q0_0");
        checkValue("wrclr_q0_zero", int'(q[0]), 0);
        for (int n = 0; n < 31; n++) begin
            checkOutput("wrclr_drain");
            applyStimulus();
        end

        // Random mixed traffic including clears and occasional resets.
        for (int n = 0; n < 300; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            c  = ($urandom_range(0, 15) == 0);
            we = ($urandom_range(0, 3) != 0);
            setIn(r, we, 5'($urandom_range(0, 31)), {$urandom, $urandom}, c);
            checkOutput("rand_mix");
            applyStimulus();
        end
        setIn(0, 0, 0, 0, 0);
        checkOutput("final");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/regfile32x64.md
REGFILE32X64 -- requirements
Module: regfile32x64

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-003 The block SHALL have port wr_en, input, 1 bit, write request for the current cycle.
REQ-004 The block SHALL have port wr_addr, input, 5 bits, destination register index 0-31.
REQ-005 The block SHALL have port wr_data, input, 64 bits, write value.
REQ-006 The block SHALL have port clr_req, input, 1 bit, single-cycle request to start a sequential clear of all registers.
REQ-007 The block SHALL have port busy, output, 1 bit, high while the clear sequence runs.
REQ-008 The block SHALL have port wr_drop, output, 1 bit, one-cycle flag that a write was discarded.
REQ-009 The block SHALL have port q, output, packed [31:0][63:0], all register contents; q[i] is register i; the bus feeds the 32:1 read-port muxes directly.

Function
REQ-010 The block SHALL hold 31 writable 64-bit registers, indices 0-30.
REQ-011 q[31] SHALL be constant zero; writes to index 31 SHALL be silently ignored, with no wr_drop.
REQ-012 In IDLE, wr_en=1 with wr_addr<31 SHALL load wr_data into register wr_addr at the clock edge; q shows the new value the following cycle.
REQ-013 The controller SHALL have two states, IDLE and CLEAR.
REQ-014 IDLE with clr_req=1 SHALL go to CLEAR with the 5-bit clear pointer set to 0.
REQ-015 Each CLEAR cycle SHALL zero register[ptr] and increment ptr.
REQ-016 In CLEAR, when ptr=30 the block SHALL zero register 30 and return to IDLE.
REQ-017 The clear sequence SHALL last exactly 31 cycles.
REQ-018 busy SHALL be registered and equal 1 exactly while the state is CLEAR, rising the cycle after clr_req is sampled.
REQ-019 In CLEAR, wr_en=1 with wr_addr<31 SHALL be discarded, with wr_drop=1 in the next cycle only.
REQ-020 In IDLE, a cycle with clr_req=1 and wr_en=1 SHALL perform the write, then enter CLEAR; the written register is later cleared.
REQ-021 clr_req while in CLEAR SHALL be ignored; the sequence SHALL NOT restart.
REQ-022 Registers not yet reached by the pointer SHALL keep their values and stay visible on q during CLEAR.

Reset
REQ-023 On reset=1 at a clock edge, all registers SHALL become 0, the state IDLE, ptr 0, busy 0 and wr_drop 0.
REQ-024 reset SHALL take priority over clr_req, wr_en and any clear sequence in progress; reset mid-clear aborts to IDLE.
REQ-025 A write presented in the same cycle as reset SHALL be lost and SHALL NOT assert wr_drop.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN SHALL control write-through on q.
REQ-027 With REGFILE_BYPASS_EN defined: when IDLE, wr_en=1 and wr_addr<31, q[wr_addr] SHALL combinationally show wr_data in the same cycle; no bypass SHALL apply in CLEAR or during reset.
REQ-028 Without REGFILE_BYPASS_EN: q SHALL reflect registered state only.

Verification
REQ-029 Bench: reset, then write 64'hDEAD_BEEF_0000_0005 to register 5 -> q[5] equals it the next cycle (the same cycle with bypass); all other q entries stay 0.
REQ-030 Bench: write 64'hFFFF_FFFF_FFFF_FFFF to register 31 -> q[31] stays 0 and wr_drop stays 0.
REQ-031 Bench: fill registers 0-30 with values i+1, pulse clr_req -> busy high for exactly 31 cycles; register k reads 0 from cycle k+2 after the pulse, while still-uncleared registers keep i+1.
REQ-032 Bench: during CLEAR, write 64'h1234 to register 30 at cycle 3 -> wr_drop pulses once; register 30 reads 0 when the clear completes.
REQ-033 Bench: assert reset at clear cycle 10 -> the next cycle busy=0 and all q=0; a following write to register 2 succeeds.
REQ-034 Bench: in IDLE, drive clr_req with a write of 64'h7 to register 0 in the same cycle -> register 0 reads 7 for one cycle, then 0; busy rises.
